fs_error_diffuser: RTL and testbench
====================================

Name: fs_error_diffuser

Overview:
Floyd-Steinberg datapath driven by the dithering loop controller's one-hot strobes (reset_dithering, store_old_p, compare_and_store_n, compute_fin). It processes one grayscale pixel per strobe sequence and produces a 1-bit output pixel. Quantization error is spread to the 4 standard neighbours through a carry register and two row error buffers. Output feeds the frame-buffer writer.

Parameters:
IMG_W, 640, pixels per row (>=2)
IMG_H, 480, rows per frame (>=1)
PIX_W, 8, input pixel width, unsigned
ACC_W, 14, signed error accumulator width, error held in 1/16 units
THRESH, 128, quantization threshold

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
reset_dithering  in  1  synchronous clear of all state
store_old_p  in  1  strobe: form corrected pixel
compare_and_store_n  in  1  strobe: quantize, compute error
compute_fin  in  1  strobe: diffuse error, advance position
pix_in  in  PIX_W  current source pixel, sampled on store_old_p
pix_out  out  1  dithered pixel
pix_valid  out  1  one-cycle pulse, pix_out/pix_col/pix_row valid
pix_col  out  $clog2(IMG_W)  column of emitted pixel
pix_row  out  $clog2(IMG_H)  row of emitted pixel
frame_done  out  1  one-cycle pulse with last pixel of frame

Behaviour:
- rst or reset_dithering: all outputs 0, col/row counters 0, both row buffers 0, right_acc 0, old_p 0, err 0, buffer select 0.
- Strobe priority if several are high: reset_dithering > compute_fin > compare_and_store_n > store_old_p. An idle cycle (no strobe) holds all state.
- The datapath has no internal FSM. The state is the col/row counters, the row buffer select bit, and the old_p/err registers.
- store_old_p: sum = pix_in + ((cur[col] + right_acc) >>> 4), where the shift is arithmetic (floor). old_p <= clamp(sum, 0, 2^PIX_W-1).
- compare_and_store_n: if old_p >= THRESH then q=1 and new=2^PIX_W-1, else q=0 and new=0. err <= old_p - new (signed, range ±(2^PIX_W-1)). q is held internally.
- compute_fin, with e=err and c=col:
  - right_acc <= 7e if c<IMG_W-1, else 0.
  - nxt[c-1] += 3e if c>0.
  - nxt[c] <= 5e if c==0, else nxt[c] += 5e.
  - nxt[c+1] <= 1e (assign, not accumulate) if c<IMG_W-1. This assign pattern clears stale data in the reused buffer.
  - All of these writes occur in the same cycle.
- The cycle after compute_fin: pix_valid=1, pix_out=q, pix_col/pix_row = position just processed. col increments.
- On col==IMG_W-1: col wraps to 0, row increments, buffer select toggles (nxt becomes cur), right_acc is 0.
- On (IMG_H-1, IMG_W-1): frame_done pulses with pix_valid. Row and col return to 0, and both buffers are left as-is. The controller must issue reset_dithering between frames.
- Latency: pix_out is valid 1 cycle after compute_fin, which is 3 strobe cycles after the pixel is sampled.
- Accumulators do not saturate. ACC_W=14 covers 16*255 worst case.
- Out-of-order strobes execute their operation on current registers; no error flag is raised.

Optional Feature:
FS_THRESH_PORT_EN:
- Defined: adds input thresh_in [PIX_W], sampled on compare_and_store_n, replacing THRESH.
- Undefined: the port is absent and the THRESH parameter is used.

Test Plan:
- Reset: assert rst mid-row -> all outputs 0, next pixel processed as (0,0) with zero error.
- IMG_W=4, IMG_H=2, first pixel pix_in=100 -> pix_out=0, err=100, right_acc=700, nxt[0]=500, nxt[1]=100.
- Second pixel pix_in=100 -> old_p=100+(700>>>4)=143, pix_out=1, err=-112, right_acc=-784.
- Clamp: pixel 120 then pixel 250 -> second old_p=255 (not 302), pix_out=1, err=0.
- Row wrap: after pixel (0,3), pix_col=3/pix_row=0 emitted, right_acc=0. Pixel (1,0) uses accumulated nxt[0]=5e0+3e1.
- Frame: 8 pixels -> frame_done exactly once, with pixel (1,3). Counters back to (0,0). FS_THRESH_PORT_EN build: thresh_in=200, pix_in=150 -> pix_out=0.

Source files
------------

// File: rtl/fs_error_diffuser.sv
// fs_error_diffuser: Floyd-Steinberg error-diffusion datapath.
// The dithering loop controller drives four one-hot strobes. For each pixel
// it issues store_old_p (form the corrected pixel), then compare_and_store_n
// (quantize and compute the error), then compute_fin (diffuse the error and
// advance the position). The error is spread to the four standard neighbours
// through right_acc and two row buffers that swap roles at the end of each row.
// Optional build macro: FS_THRESH_PORT_EN adds a run-time threshold input
// thresh_in that replaces the THRESH parameter.
module fs_error_diffuser #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int PIX_W  = 8,
  parameter int ACC_W  = 14,
  parameter int THRESH = 128
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       reset_dithering,
  input  logic                                       store_old_p,
  input  logic                                       compare_and_store_n,
  input  logic                                       compute_fin,
  input  logic [PIX_W-1:0]                           pix_in,
`ifdef FS_THRESH_PORT_EN
  input  logic [PIX_W-1:0]                           thresh_in,
`endif
  output logic                                       pix_out,
  output logic                                       pix_valid,
  output logic [$clog2(IMG_W)-1:0]                   pix_col,
  output logic [((IMG_H > 1) ? $clog2(IMG_H) : 1)-1:0] pix_row,
  output logic                                       frame_done
);

  // A single-row image still needs a 1-bit row counter.
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [PIX_W-1:0] PIX_MAX = {PIX_W{1'b1}};
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

  typedef logic signed [ACC_W-1:0] acc_t;

  // Row buffers. sel=0: buf0 is the current row, buf1 collects the next row.
  acc_t buf0 [IMG_W];
  acc_t buf1 [IMG_W];
  acc_t nxt_rd  [IMG_W];
  acc_t nxt_val [IMG_W];

  acc_t                   right_acc;
  logic [PIX_W-1:0]       old_p;
  logic signed [PIX_W:0]  err;
  logic                   q;
  logic                   sel;
  logic [COL_W-1:0]       col;
  logic [ROW_W-1:0]       row;

  logic                   is_last_col;
  logic                   is_last_row;
  logic [PIX_W:0]         thr;
  acc_t                   cur_rd;
  acc_t                   e1;
  acc_t                   e3;
  acc_t                   e5;
  acc_t                   e7;
  logic signed [ACC_W+1:0] acc_sum;
  logic signed [ACC_W+1:0] acc_shift;
  logic signed [ACC_W+1:0] pix_ext;
  logic signed [ACC_W+1:0] sum_full;
  logic [PIX_W-1:0]       clamped;

  assign is_last_col = (col == LAST_COL);
  assign is_last_row = (row == LAST_ROW);

`ifdef FS_THRESH_PORT_EN
  assign thr = {1'b0, thresh_in};
`else
  assign thr = (PIX_W + 1)'(THRESH);
`endif

  // Corrected pixel: source plus floored sixteenth of the error that
  // arrived from the row above and from the left neighbour, clamped to range.
  always_comb begin
    cur_rd    = sel ? buf1[col] : buf0[col];
    acc_sum   = {{2{cur_rd[ACC_W-1]}}, cur_rd} + {{2{right_acc[ACC_W-1]}}, right_acc};
    acc_shift = acc_sum >>> 4;
    pix_ext   = {{(ACC_W + 2 - PIX_W){1'b0}}, pix_in};
    sum_full  = pix_ext + acc_shift;
    if (sum_full < 0)
      clamped = '0;
    else if (sum_full > $signed({{(ACC_W + 2 - PIX_W){1'b0}}, PIX_MAX}))
      clamped = PIX_MAX;
    else
      clamped = sum_full[PIX_W-1:0];
  end

  // Error multiples in 1/16 units, built from shifts and adds.
  always_comb begin
    e1 = {{(ACC_W - PIX_W - 1){err[PIX_W]}}, err};
    e3 = (e1 <<< 1) + e1;
    e5 = (e1 <<< 2) + e1;
    e7 = (e1 <<< 3) - e1;
  end

  // Next-row buffer contents after a compute_fin at the current column:
  // accumulate 3e to the lower-left, 5e below (assign at column 0), and
  // assign 1e to the lower-right so stale data from two rows ago is cleared.
  always_comb begin
    for (int i = 0; i < IMG_W; i++) begin
      nxt_rd[i]  = sel ? buf0[i] : buf1[i];
      nxt_val[i] = nxt_rd[i];
      if (i == int'(col))
        nxt_val[i] = (col == '0) ? e5 : nxt_rd[i] + e5;
      else if (i + 1 == int'(col))
        nxt_val[i] = nxt_rd[i] + e3;
      else if (i == int'(col) + 1)
        nxt_val[i] = e1;
    end
  end

  // Main strobe-driven state update, highest priority first:
  // reset_dithering, compute_fin, compare_and_store_n, store_old_p.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IMG_W; i++) begin
        buf0[i] <= '0;
        buf1[i] <= '0;
      end
      right_acc  <= '0;
      old_p      <= '0;
      err        <= '0;
      q          <= 1'b0;
      sel        <= 1'b0;
      col        <= '0;
      row        <= '0;
      pix_out    <= 1'b0;
      pix_valid  <= 1'b0;
      pix_col    <= '0;
      pix_row    <= '0;
      frame_done <= 1'b0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (reset_dithering) begin
        for (int i = 0; i < IMG_W; i++) begin
          buf0[i] <= '0;
          buf1[i] <= '0;
        end
        right_acc <= '0;
        old_p     <= '0;
        err       <= '0;
        q         <= 1'b0;
        sel       <= 1'b0;
        col       <= '0;
        row       <= '0;
        pix_out   <= 1'b0;
        pix_col   <= '0;
        pix_row   <= '0;
      end else if (compute_fin) begin
        if (sel)
          buf0 <= nxt_val;
        else
          buf1 <= nxt_val;
        right_acc  <= is_last_col ? '0 : e7;
        pix_valid  <= 1'b1;
        pix_out    <= q;
        pix_col    <= col;
        pix_row    <= row;
        frame_done <= is_last_col && is_last_row;
        if (is_last_col) begin
          col <= '0;
          sel <= ~sel;
          row <= is_last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else if (compare_and_store_n) begin
        if ({1'b0, old_p} >= thr) begin
          q   <= 1'b1;
          err <= $signed({1'b0, old_p}) - $signed({1'b0, PIX_MAX});
        end else begin
          q   <= 1'b0;
          err <= $signed({1'b0, old_p});
        end
      end else if (store_old_p) begin
        old_p <= clamped;
      end
    end
  end

endmodule

// File: tb/tb_fs_error_diffuser.sv
// tb_fs_error_diffuser: directed bench for fs_error_diffuser on a 4x2 image.
// Expected values are hand-computed Floyd-Steinberg results; with
// FS_THRESH_PORT_EN defined the threshold is driven through thresh_in.
module tb_fs_error_diffuser;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int PIX_W = 8;
  localparam int ACC_W = 14;

  logic       clk;
  logic       rst;
  logic       reset_dithering;
  logic       store_old_p;
  logic       compare_and_store_n;
  logic       compute_fin;
  logic [7:0] pix_in;
`ifdef FS_THRESH_PORT_EN
  logic [7:0] thresh_in;
`endif
  logic       pix_out;
  logic       pix_valid;
  logic [1:0] pix_col;
  logic [0:0] pix_row;
  logic       frame_done;

  int checkCount;
  int errorCount;
  int frameDoneCount;

  fs_error_diffuser #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .PIX_W (PIX_W),
    .ACC_W (ACC_W),
    .THRESH(128)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .reset_dithering    (reset_dithering),
    .store_old_p        (store_old_p),
    .compare_and_store_n(compare_and_store_n),
    .compute_fin        (compute_fin),
    .pix_in             (pix_in),
`ifdef FS_THRESH_PORT_EN
    .thresh_in          (thresh_in),
`endif
    .pix_out            (pix_out),
    .pix_valid          (pix_valid),
    .pix_col            (pix_col),
    .pix_row            (pix_row),
    .frame_done         (frame_done)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_done pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_done) frameDoneCount = frameDoneCount + 1;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount = checkCount + 1;
    if (observed !== expected) begin
      errorCount = errorCount + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One-cycle strobe helpers; inputs change #1 after the rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Runs the three-strobe sequence for one pixel and checks every stage.
  task automatic applyStimulus(input string name, input int pix,
                               input int expOld, input int expErr,
                               input int expRa, input int expOut,
                               input int expCol, input int expRow,
                               input int expFd);
    pix_in = 8'(pix);
    store_old_p = 1'b1;
    stepCycle();
    store_old_p = 1'b0;
    checkOutput({name, ".old_p"}, int'(dut.old_p), expOld);
    compare_and_store_n = 1'b1;
    stepCycle();
    compare_and_store_n = 1'b0;
    checkOutput({name, ".err"}, int'(dut.err), expErr);
    compute_fin = 1'b1;
    stepCycle();
    compute_fin = 1'b0;
    checkOutput({name, ".pix_valid"}, int'(pix_valid), 1);
    checkOutput({name, ".pix_out"}, int'(pix_out), expOut);
    checkOutput({name, ".pix_col"}, int'(pix_col), expCol);
    checkOutput({name, ".pix_row"}, int'(pix_row), expRow);
    checkOutput({name, ".frame_done"}, int'(frame_done), expFd);
    checkOutput({name, ".right_acc"}, int'(dut.right_acc), expRa);
    stepCycle();
    checkOutput({name, ".valid_pulse"}, int'(pix_valid), 0);
  endtask

  initial begin
    checkCount          = 0;
    errorCount          = 0;
    frameDoneCount      = 0;
    rst                 = 1'b1;
    reset_dithering     = 1'b0;
    store_old_p         = 1'b0;
    compare_and_store_n = 1'b0;
    compute_fin         = 1'b0;
    pix_in              = 8'd0;
`ifdef FS_THRESH_PORT_EN
    thresh_in           = 8'd128;
`endif
    repeat (2) stepCycle();
    rst = 1'b0;
    stepCycle();

    $display("[TB] reset state");
    checkOutput("rst.pix_out", int'(pix_out), 0);
    checkOutput("rst.pix_valid", int'(pix_valid), 0);
    checkOutput("rst.frame_done", int'(frame_done), 0);
    checkOutput("rst.col", int'(dut.col), 0);

    $display("[TB] async reset mid-row");
    applyStimulus("r0", 100, 100, 100, 700, 0, 0, 0, 0);
    applyStimulus("r1", 100, 143, -112, -784, 1, 1, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #2;
    checkOutput("arst.pix_out", int'(pix_out), 0);
    checkOutput("arst.pix_col", int'(pix_col), 0);
    checkOutput("arst.right_acc", int'(dut.right_acc), 0);
    checkOutput("arst.col", int'(dut.col), 0);
    checkOutput("arst.buf1_0", int'(dut.buf1[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    stepCycle();
    applyStimulus("r2", 100, 100, 100, 700, 0, 0, 0, 0);

    $display("[TB] idle hold");
    repeat (3) stepCycle();
    checkOutput("idle.right_acc", int'(dut.right_acc), 700);
    checkOutput("idle.col", int'(dut.col), 1);
    checkOutput("idle.pix_valid", int'(pix_valid), 0);

    $display("[TB] reset_dithering outranks compute_fin");
    reset_dithering = 1'b1;
    compute_fin     = 1'b1;
    stepCycle();
    reset_dithering = 1'b0;
    compute_fin     = 1'b0;
    checkOutput("prio.pix_valid", int'(pix_valid), 0);
    checkOutput("prio.right_acc", int'(dut.right_acc), 0);
    checkOutput("prio.col", int'(dut.col), 0);
    checkOutput("prio.buf1_0", int'(dut.buf1[0]), 0);

    $display("[TB] full 4x2 frame");
    frameDoneCount = 0;
    applyStimulus("p00", 100, 100, 100, 700, 0, 0, 0, 0);
    checkOutput("p00.nxt0", int'(dut.buf1[0]), 500);
    checkOutput("p00.nxt1", int'(dut.buf1[1]), 100);
    applyStimulus("p01", 100, 143, -112, -784, 1, 1, 0, 0);
    applyStimulus("p02", 120, 71, 71, 497, 0, 2, 0, 0);
    applyStimulus("p03", 250, 255, 0, 0, 1, 3, 0, 0);
    checkOutput("wrap.row", int'(dut.row), 1);
    checkOutput("wrap.col", int'(dut.col), 0);
    checkOutput("wrap.nxt0", int'(dut.buf1[0]), 164);
    checkOutput("wrap.nxt1", int'(dut.buf1[1]), -247);
    checkOutput("wrap.nxt2", int'(dut.buf1[2]), 243);
    applyStimulus("p10", 50, 60, 60, 420, 0, 0, 1, 0);
    checkOutput("p10.nxt0", int'(dut.buf0[0]), 300);
    applyStimulus("p11", 200, 210, -45, -315, 1, 1, 1, 0);
    applyStimulus("p12", 0, 0, 0, 0, 0, 2, 1, 0);
    applyStimulus("p13", 130, 134, -121, 0, 1, 3, 1, 1);
    checkOutput("frame.done_count", frameDoneCount, 1);
    checkOutput("frame.col", int'(dut.col), 0);
    checkOutput("frame.row", int'(dut.row), 0);

`ifdef FS_THRESH_PORT_EN
    $display("[TB] run-time threshold");
    reset_dithering = 1'b1;
    stepCycle();
    reset_dithering = 1'b0;
    thresh_in = 8'd200;
    applyStimulus("th", 150, 150, 150, 1050, 0, 0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
